qr_cordic_scheduler: RTL
========================

# qr_cordic_scheduler

Round-robin scheduler that shares one 4x4 QR CORDIC engine between two matrix requesters. It sits between two sample-stream sources and the engine's `in_valid`/`in` port. It forwards exactly one 16-sample matrix frame from the granted requester, then waits for the engine's 16-cycle result burst. It routes that burst back tagged with the requester ID and enforces the engine's idle gap before granting again.

## Interface
- `INPUT_DATA_WIDTH`, 8, width of matrix samples (engine `in` width)
- `Q_DATA_WIDTH`, 12, width of engine `out_r`/`out_q`
- `FRAME_LEN`, 16, samples per input frame and results per output burst
- `GAP_CYC`, 1, idle cycles after a burst before the next grant (engine IDLE state)
- `TIMEOUT_CYC`, 64, max cycles in WAIT before timeout (used only with macro)

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `req_valid`  in  2  per-requester sample valid
- `req_data`  in  2*INPUT_DATA_WIDTH  samples; requester k at bits [k*W +: W]
- `req_ready`  out  2  per-requester sample accept
- `eng_in_valid`  out  1  to engine `in_valid`
- `eng_in`  out  INPUT_DATA_WIDTH  to engine `in`
- `eng_out_valid`  in  1  from engine `out_valid`
- `eng_out_r`, `eng_out_q`  in  Q_DATA_WIDTH each  from engine
- `res_valid`  out  1  result sample valid (no backpressure)
- `res_id`  out  1  requester owning the result
- `res_r`, `res_q`  out  Q_DATA_WIDTH each  registered engine results
- `res_last`  out  1  marks the FRAME_LEN-th result of a burst
- `busy`  out  1  high in any state other than ARB
- `err`  out  2  sticky; bit0 protocol error, bit1 timeout

## Operation
- States: ARB, LOAD, WAIT, OUT, GAP. Reset state is ARB.
- ARB:
  - If any `req_valid` is set, register `grant` by round-robin and go to LOAD.
  - Priority goes to the requester other than `last_grant`. `last_grant` resets to 1, so requester 0 wins the first tie.
  - With no requests, stay in ARB.
- LOAD:
  - `req_ready[grant]=1` combinationally; the other ready bit is 0.
  - `eng_in_valid = req_valid[grant]`; `eng_in = req_data[grant]`. Both are combinational pass-through.
  - A transfer is valid&&ready; it increments `cnt`.
  - Source gaps are allowed indefinitely; the engine counts only valid samples.
  - On the FRAME_LEN-th transfer, clear `cnt`, set `last_grant=grant`, and go to WAIT.
- WAIT:
  - On `eng_out_valid`, capture the first result and go to OUT with `cnt=1`.
- OUT:
  - Each `eng_out_valid` cycle captures one result and increments `cnt`.
  - When the FRAME_LEN-th result is captured, go to GAP.
  - If `eng_out_valid` drops before FRAME_LEN results, set `err[0]` and go to GAP.
- GAP: hold for GAP_CYC cycles, then go to ARB.
- Result capture:
  - `res_valid <= eng_out_valid` in WAIT/OUT, else 0.
  - `res_r`/`res_q` are loaded from the engine on capture; `res_id <= grant`.
  - `res_last` is high with the FRAME_LEN-th capture.
- `eng_out_valid` in ARB, LOAD or GAP is ignored for results and sets `err[0]`.
- `err` bits clear only on reset.
- Widths: data is passed unmodified; no arithmetic on samples. Counters are $clog2(FRAME_LEN+1) bits and TIMEOUT counter $clog2(TIMEOUT_CYC+1) bits.

## Timing
- Reset values:
  - All outputs are 0 (`req_ready`, `eng_in_valid`, `eng_in`, `res_*`, `busy`, `err`).
  - `grant=0`, `last_grant=1`, counters 0, state ARB.
- Grant latency: `req_valid` sampled in ARB at edge N gives `req_ready` high from cycle N+1.
- Sample path latency is 0 cycles (combinational); result path latency is 1 cycle (`eng_out_*` to `res_*`).
- Minimum frame-to-frame spacing: FRAME_LEN load + engine compute + FRAME_LEN out + GAP_CYC + 1 ARB cycle.
- Both requesters valid in ARB: exactly one grant; the loser's `req_ready` stays 0 and its data must be held.
- Reset mid-operation: the block returns to ARB immediately. The engine shares `rst_n` and restarts in its read state, so no partial frame survives.

## Configuration
- `QR_SCHED_TIMEOUT_EN` defined:
  - A counter runs in WAIT.
  - If TIMEOUT_CYC cycles elapse with no `eng_out_valid`, set `err[1]`, pulse nothing else, and go to GAP.
- `QR_SCHED_TIMEOUT_EN` undefined:
  - No counter; WAIT persists indefinitely.
  - `err[1]` is tied to 0 and the TIMEOUT_CYC parameter is unused.

## Test plan
- Single frame: requester 0 streams samples 1..16 back-to-back. Expect 16 `eng_in_valid` pulses with `eng_in`=1..16, then 16 `res_valid` with `res_id=0`, `res_last` only on the 16th, then `busy` low after GAP_CYC+1 cycles.
- Contention: both `req_valid` high from reset. Expect requester 0 granted first, requester 1 second, requester 0 third; `req_ready[1]` stays 0 throughout frame 0.
- Gapped source: requester 1 drops `req_valid` every other cycle. Expect exactly 16 transfers over 31 cycles and no early transition to WAIT.
- Spurious engine output: `eng_out_valid` pulsed during LOAD. Expect `err=2'b01`, no `res_valid`, and the frame continues normally.
- Truncated burst: engine model drives 10 result cycles then stops. Expect 10 `res_valid`, no `res_last`, `err[0]=1`, and return to ARB.
- Timeout (macro on, TIMEOUT_CYC=64): engine silent after the frame. Expect `err[1]=1` at cycle 64 of WAIT and the state reaching ARB GAP_CYC+1 cycles later. With the macro off, `busy` stays 1.

Source files
------------

// File: rtl/qr_cordic_scheduler.sv
// qr_cordic_scheduler
// Round-robin front end that shares one 4x4 QR CORDIC engine between two
// sample-stream requesters. One FRAME_LEN-sample frame is forwarded from the
// granted requester, the engine's result burst is registered and tagged with
// the requester ID, then an idle gap is enforced before the next grant.
// Optional WAIT-state timeout is compiled in with `define QR_SCHED_TIMEOUT_EN.
module qr_cordic_scheduler #(
    parameter int INPUT_DATA_WIDTH = 8,
    parameter int Q_DATA_WIDTH     = 12,
    parameter int FRAME_LEN        = 16,
    parameter int GAP_CYC          = 1,
    parameter int TIMEOUT_CYC      = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    req_valid,
    input  logic [2*INPUT_DATA_WIDTH-1:0] req_data,
    output logic [1:0]                    req_ready,
    output logic                          eng_in_valid,
    output logic [INPUT_DATA_WIDTH-1:0]   eng_in,
    input  logic                          eng_out_valid,
    input  logic [Q_DATA_WIDTH-1:0]       eng_out_r,
    input  logic [Q_DATA_WIDTH-1:0]       eng_out_q,
    output logic                          res_valid,
    output logic                          res_id,
    output logic [Q_DATA_WIDTH-1:0]       res_r,
    output logic [Q_DATA_WIDTH-1:0]       res_q,
    output logic                          res_last,
    output logic                          busy,
    output logic [1:0]                    err
);

    localparam int CNT_W = $clog2(FRAME_LEN + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    typedef enum logic [2:0] {
        ARB  = 3'd0,
        LOAD = 3'd1,
        WAIT = 3'd2,
        OUT  = 3'd3,
        GAP  = 3'd4
    } state_t;

    // A zero-length gap returns straight to arbitration after a burst.
    localparam state_t AFTER_BURST = state_t'((GAP_CYC > 0) ? 3'd4 : 3'd0);

    state_t                  state;
    state_t                  state_next;
    logic                    grant;
    logic                    grant_next;
    logic                    last_grant;
    logic                    last_grant_next;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    logic [GAP_W-1:0]        gap_cnt;
    logic [GAP_W-1:0]        gap_cnt_next;
    logic                    capture;
    logic                    last_capture;
    logic                    proto_err;
    logic                    err_proto;

    logic                    res_valid_p1;
    logic                    res_id_p1;
    logic                    res_last_p1;
    logic [Q_DATA_WIDTH-1:0] res_r_p1;
    logic [Q_DATA_WIDTH-1:0] res_q_p1;

`ifdef QR_SCHED_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [TO_W-1:0]         to_cnt;
    logic [TO_W-1:0]         to_cnt_next;
    logic                    timeout_err;
    logic                    err_timeout;
`endif

    // Next-state, counter updates and the combinational sample path
    always_comb begin
        state_next      = state;
        grant_next      = grant;
        last_grant_next = last_grant;
        cnt_next        = cnt;
        gap_cnt_next    = gap_cnt;
        capture         = 1'b0;
        last_capture    = 1'b0;
        proto_err       = 1'b0;
        req_ready       = 2'b00;
        eng_in_valid    = 1'b0;
        eng_in          = '0;
`ifdef QR_SCHED_TIMEOUT_EN
        to_cnt_next     = to_cnt;
        timeout_err     = 1'b0;
`endif
        unique case (state)
            ARB: begin
                // Engine output outside a burst is a protocol violation.
                proto_err = eng_out_valid;
                if (|req_valid) begin
                    // Prefer the requester that was not served last.
                    grant_next = req_valid[~last_grant] ? ~last_grant : last_grant;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                req_ready[grant] = 1'b1;
                eng_in_valid     = req_valid[grant];
                eng_in           = grant ? req_data[2*INPUT_DATA_WIDTH-1:INPUT_DATA_WIDTH]
                                         : req_data[INPUT_DATA_WIDTH-1:0];
                proto_err        = eng_out_valid;
                if (req_valid[grant]) begin
                    if (cnt == CNT_LAST) begin
                        cnt_next        = '0;
                        last_grant_next = grant;
                        state_next      = WAIT;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end
            end
            WAIT: begin
                if (eng_out_valid) begin
                    capture = 1'b1;
                    if (FRAME_LEN == 1) begin
                        last_capture = 1'b1;
                        cnt_next     = '0;
                        state_next   = AFTER_BURST;
                    end else begin
                        cnt_next   = CNT_ONE;
                        state_next = OUT;
                    end
                end
`ifdef QR_SCHED_TIMEOUT_EN
                // Count silent WAIT cycles; give up after TIMEOUT_CYC of them.
                to_cnt_next = '0;
                if (!eng_out_valid) begin
                    if (to_cnt == TO_LAST) begin
                        timeout_err = 1'b1;
                        state_next  = AFTER_BURST;
                    end else begin
                        to_cnt_next = to_cnt + TO_ONE;
                    end
                end
`endif
            end
            OUT: begin
                if (eng_out_valid) begin
                    capture = 1'b1;
                    if (cnt == CNT_LAST) begin
                        last_capture = 1'b1;
                        cnt_next     = '0;
                        state_next   = AFTER_BURST;
                    end else begin
                        cnt_next = cnt + CNT_ONE;
                    end
                end else begin
                    // Burst ended early: flag it and abandon the rest.
                    proto_err  = 1'b1;
                    cnt_next   = '0;
                    state_next = AFTER_BURST;
                end
            end
            GAP: begin
                proto_err = eng_out_valid;
                if (gap_cnt == GAP_LAST) begin
                    gap_cnt_next = '0;
                    state_next   = ARB;
                end else begin
                    gap_cnt_next = gap_cnt + GAP_ONE;
                end
            end
            default: begin
                state_next = ARB;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARB;
        end else begin
            state <= state_next;
        end
    end

    // Arbitration, frame/gap counters and sticky protocol error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            cnt        <= '0;
            gap_cnt    <= '0;
            err_proto  <= 1'b0;
        end else begin
            grant      <= grant_next;
            last_grant <= last_grant_next;
            cnt        <= cnt_next;
            gap_cnt    <= gap_cnt_next;
            err_proto  <= err_proto | proto_err;
        end
    end

`ifdef QR_SCHED_TIMEOUT_EN
    // WAIT timeout counter and sticky timeout flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_next;
            err_timeout <= err_timeout | timeout_err;
        end
    end

    assign err = {err_timeout, err_proto};
`else
    assign err = {1'b0, err_proto};
`endif

    // Result capture stage: one-cycle registered copy of the engine burst
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_p1 <= 1'b0;
            res_last_p1  <= 1'b0;
            res_id_p1    <= 1'b0;
            res_r_p1     <= '0;
            res_q_p1     <= '0;
        end else begin
            res_valid_p1 <= capture;
            res_last_p1  <= last_capture;
            if (capture) begin
                res_id_p1 <= grant;
                res_r_p1  <= eng_out_r;
                res_q_p1  <= eng_out_q;
            end
        end
    end

    assign res_valid = res_valid_p1;
    assign res_last  = res_last_p1;
    assign res_id    = res_id_p1;
    assign res_r     = res_r_p1;
    assign res_q     = res_q_p1;
    assign busy      = (state != ARB);

endmodule
